// File: rtl/axi_llc_way_scrub_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_llc_way_scrub_ctrl_if
//  Description : Way-request and scrub-response bundle between the functional
//                request merge, the scrub controller and the way crossbar.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_llc_way_scrub_ctrl_if #(
  parameter int NumWays = 8,
  parameter int LineW   = 8
);
  logic               fn_valid_i;
  logic [NumWays-1:0] fn_way_ind_i;
  logic               fn_ready_o;
  logic               out_valid_o;
  logic               out_ready_i;
  logic               out_scrub_o;
  logic [NumWays-1:0] out_way_ind_o;
  logic [LineW-1:0]   out_line_o;
  logic               scrub_rsp_valid_i;
  logic               scrub_rsp_err_i;

  // Controller side
  modport slave (
    input  fn_valid_i,
    input  fn_way_ind_i,
    input  out_ready_i,
    input  scrub_rsp_valid_i,
    input  scrub_rsp_err_i,
    output fn_ready_o,
    output out_valid_o,
    output out_scrub_o,
    output out_way_ind_o,
    output out_line_o
  );

  // Environment side: functional source, crossbar and response return
  modport master (
    output fn_valid_i,
    output fn_way_ind_i,
    output out_ready_i,
    output scrub_rsp_valid_i,
    output scrub_rsp_err_i,
    input  fn_ready_o,
    input  out_valid_o,
    input  out_scrub_o,
    input  out_way_ind_o,
    input  out_line_o
  );
endinterface
`default_nettype wire

// File: rtl/axi_llc_way_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : axi_llc_way_scrub_ctrl
//  Description : Background ECC scrub sequencer for the LLC data ways; walks
//                every (line, way) pair, arbitrates against functional traffic
//                with a starvation bound and counts scrub ECC errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_llc_way_scrub_ctrl #(
  parameter int NumWays     = 8,
  parameter int NumLines    = 256,
  parameter int ScrubPeriod = 1024,
  parameter int MaxStall    = 16
) (
  input  wire logic                clk_i,
  input  wire logic                rst_ni,
  input  wire logic                en_i,
  input  wire logic                err_clr_i,
  axi_llc_way_scrub_ctrl_if.slave  bus,
  output logic                     busy_o,
  output logic                     pass_done_o,
  output logic [15:0]              err_cnt_o
);

  localparam int c_line_w  = (NumLines > 1) ? $clog2(NumLines) : 1;
  localparam int c_way_w   = (NumWays > 1) ? $clog2(NumWays) : 1;
  localparam int c_stall_w = $clog2(MaxStall + 1);
  localparam int c_timer_w = $clog2(ScrubPeriod + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LK_NONE  = 2'd0,
    LK_FN    = 2'd1,
    LK_SCRUB = 2'd2
  } lock_t;

  state_t                r_state;
  lock_t                 r_lock;
  logic [c_timer_w-1:0]  r_timer;
  logic [c_stall_w-1:0]  r_stall;
  logic [c_way_w-1:0]    r_way_ptr;
  logic [c_line_w-1:0]   r_line_ptr;
  logic [15:0]           r_err_cnt;
  logic                  r_pass_done;

  logic                  w_stall_ok;
  logic                  w_req_active;
  logic                  w_sel_scrub;
  logic                  w_fn_arb;
  logic                  w_hs_scrub;
  logic                  w_err_hit;
  logic                  w_way_last;
  logic                  w_line_last;
  logic [NumWays-1:0]    w_way_onehot;

  assign w_stall_ok   = (r_stall < c_stall_w'(MaxStall));
  // Dropping en_i only aborts REQ when nothing is locked onto the port.
  assign w_req_active = (r_state == ST_REQ) && ((r_lock != LK_NONE) || en_i);
  assign w_sel_scrub  = w_req_active &&
                        ((r_lock == LK_SCRUB) ||
                         ((r_lock == LK_NONE) && !(bus.fn_valid_i && w_stall_ok)));
  assign w_fn_arb     = w_req_active && (r_lock == LK_NONE) &&
                        bus.fn_valid_i && w_stall_ok;
  assign w_hs_scrub   = w_sel_scrub && bus.out_ready_i;
  assign w_err_hit    = (r_state == ST_WAIT) && bus.scrub_rsp_valid_i &&
                        bus.scrub_rsp_err_i;
  assign w_way_last   = (r_way_ptr == c_way_w'(NumWays - 1));
  assign w_line_last  = (r_line_ptr == c_line_w'(NumLines - 1));

  always_comb begin
    w_way_onehot            = '0;
    w_way_onehot[r_way_ptr] = 1'b1;
  end

  // Port mux: functional passthrough unless the scrub owns the grant.
  always_comb begin
    bus.out_valid_o   = bus.fn_valid_i;
    bus.fn_ready_o    = bus.out_ready_i;
    bus.out_scrub_o   = 1'b0;
    bus.out_way_ind_o = bus.fn_way_ind_i;
    bus.out_line_o    = '0;
    if (w_sel_scrub) begin
      bus.out_valid_o   = 1'b1;
      bus.fn_ready_o    = 1'b0;
      bus.out_scrub_o   = 1'b1;
      bus.out_way_ind_o = w_way_onehot;
      bus.out_line_o    = r_line_ptr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_lock      <= LK_NONE;
      r_timer     <= '0;
      r_stall     <= '0;
      r_way_ptr   <= '0;
      r_line_ptr  <= '0;
      r_err_cnt   <= '0;
      r_pass_done <= 1'b0;
    end else begin
      r_pass_done <= 1'b0;

      // A clear coincident with a counted error keeps that error.
      if (err_clr_i) begin
        r_err_cnt <= {15'd0, w_err_hit};
      end else if (w_err_hit && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end

      case (r_state)
        ST_IDLE: begin
          r_lock <= LK_NONE;
          if (!en_i) begin
            r_timer <= '0;
          end else if (r_timer == c_timer_w'(ScrubPeriod - 1)) begin
            r_timer <= '0;
            r_state <= ST_REQ;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_REQ: begin
          if (w_fn_arb) begin
            r_stall <= r_stall + 1'b1;
          end
          if (w_hs_scrub) begin
            r_stall <= '0;
            r_lock  <= LK_NONE;
            r_state <= ST_WAIT;
          end else if (w_sel_scrub) begin
            r_lock <= LK_SCRUB;
          end else if (w_req_active && bus.fn_valid_i && !bus.out_ready_i) begin
            r_lock <= LK_FN;
          end else begin
            r_lock <= LK_NONE;
            if (!en_i) begin
              r_state <= ST_IDLE;
            end
          end
        end

        ST_WAIT: begin
          if (bus.scrub_rsp_valid_i) begin
            if (w_way_last) begin
              r_way_ptr <= '0;
              if (w_line_last) begin
                r_line_ptr  <= '0;
                r_pass_done <= 1'b1;
              end else begin
                r_line_ptr <= r_line_ptr + 1'b1;
              end
            end else begin
              r_way_ptr <= r_way_ptr + 1'b1;
            end
            r_timer <= '0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_lock  <= LK_NONE;
        end
      endcase
    end
  end

  assign busy_o      = (r_state != ST_IDLE);
  assign pass_done_o = r_pass_done;
  assign err_cnt_o   = r_err_cnt;

endmodule
`default_nettype wire
